dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder on the far side of the pipelined CPU's MEM-stage load/store port.
//  The CPU is the initiator: it raises req with we/addr/wdata and holds them until ready.
//  This block accepts the request, inserts LATENCY wait cycles, then returns read data or commits the write.
//  It drives stall back to the pipeline so hazard logic freezes earlier stages while an access is outstanding.
// PARAMETERS
//  DEPTH    64  number of 32-bit words; power of two
//  LATENCY  2   wait cycles between acceptance and response; legal range 0..7
// PORTS
//  clock   in   1   single clock, rising edge
//  reset   in   1   asynchronous, active-high reset
//  req     in   1   access request from MEM stage; held until ready
//  we      in   1   1 = store, 0 = load; valid with req
//  addr    in   32  byte address; valid with req
//  wdata   in   32  store data; valid with req
//  rdata   out  32  load data; valid only while ready=1
//  ready   out  1   one-cycle response pulse
//  err     out  1   qualifies ready; access was faulted
//  stall   out  1   pipeline freeze request
// BEHAVIOUR
//  Reset: state=IDLE; rdata=0, ready=0, err=0, latched request cleared. Memory contents are not cleared.
//  FSM states: IDLE, WAIT, RESP.
//   IDLE: when req=1, latch we/addr/wdata at the clock edge and load cnt=LATENCY.
//         Next state is WAIT if LATENCY>0, else RESP.
//   WAIT: cnt decrements each cycle. At cnt==1 -> RESP.
//   RESP: ready=1 for exactly one cycle, then -> IDLE unconditionally. req in RESP is ignored.
//  Latency: req sampled at edge t -> ready high during cycle t+1+LATENCY. One idle cycle separates back-to-back accesses.
//  stall = (IDLE & req) | WAIT. stall=0 in RESP so the pipeline advances on the response cycle.
//  Word index = addr[2 +: log2(DEPTH)].
//  Fault when addr[1:0]!=0 or addr >= 4*DEPTH:
//   - full latency still applies;
//   - in RESP: ready=1, err=1, rdata=0;
//   - no write occurs.
//  Load: rdata registered on entry to RESP from mem[index]. Reads the value present before this access.
//  Store: mem[index] <= wdata on the edge leaving RESP. rdata=0 during a store response.
//  Read-after-write: a load accepted after a store's RESP returns the new value.
//  Request fields changing in WAIT have no effect; only the latched copy is used.
//  Reset asserted mid-access: immediate return to IDLE, outputs cleared, pending store discarded (memory unchanged).
//  Reset deasserted with req=1: request accepted at the first clock edge after deassertion.
//  ready and err are never high outside RESP.
// STRUCTURE
//  Shared header dmem_defs.vh:
//   - state encodings IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
//   - WORD_BYTES=4;
//   - fault-code constants reused by the instruction-memory responder.
//  One sub-module dmem_array:
//   - DEPTH x 32 storage;
//   - synchronous write enable;
//   - registered read port.
//  FSM, counter, address check and latches stay in dmem_responder.
// TESTING
//  1 Reset: reset=1 mid-WAIT of a store to 0x10 -> next cycle ready=0, stall=0; later load of 0x10 returns its old value.
//  2 Store/load: LATENCY=2, store 0xDEADBEEF @0x08 -> ready at t+3, stall high 3 cycles;
//    then load @0x08 -> rdata=0xDEADBEEF, err=0.
//  3 LATENCY=0: load @0x04 -> ready in cycle t+1, stall high exactly 1 cycle.
//  4 Misaligned store @0x0A -> ready+err at t+3, rdata=0; load @0x08 still returns prior value.
//  5 Out-of-range load @0x100 with DEPTH=64 -> err=1, rdata=0.
//  6 Change addr/wdata during WAIT of store @0x0C -> value stored at 0x0C is the originally latched wdata.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states, word size and
// fault classification (fault codes are also used by the instruction-memory responder).
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_MISALIGN = 2'd1,
        FAULT_RANGE    = 2'd2
    } fault_t;

    // Classify a byte address against a memory of 'depth' words.
    function automatic fault_t addr_fault(input logic [31:0] addr, input int unsigned depth);
        if (addr[1:0] != 2'b00) begin
            return FAULT_MISALIGN;
        end
        if (addr >= 32'(depth * WORD_BYTES)) begin
            return FAULT_RANGE;
        end
        return FAULT_NONE;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage with a synchronous write port and a registered,
// read-first read port; contents are intentionally not reset.
module dmem_array #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: accepts one access, waits LATENCY cycles,
// then pulses ready with load data or commits the store, stalling the pipeline meanwhile.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        stall
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic          accept;
    fault_t        fault;
    logic          ok;
    logic          mem_we;
    logic [AW-1:0] rd_idx;
    logic [31:0]   arr_rdata;

    assign accept = (state_q == IDLE) && req;
    assign fault  = addr_fault(addr_q, DEPTH);
    assign ok     = (fault == FAULT_NONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_d   = 3'(LATENCY);
                    state_d = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With zero latency the array must be addressed from the live request,
    // so its registered output is valid on the very next (response) cycle.
    assign rd_idx = (state_q == IDLE) ? addr[2 +: AW] : addr_q[2 +: AW];
    assign mem_we = (state_q == RESP) && we_q && ok;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clock (clock),
        .we    (mem_we),
        .waddr (addr_q[2 +: AW]),
        .wdata (wdata_q),
        .raddr (rd_idx),
        .rdata (arr_rdata)
    );

    assign ready = (state_q == RESP);
    assign err   = (state_q == RESP) && !ok;
    assign rdata = ((state_q == RESP) && !we_q && ok) ? arr_rdata : 32'd0;
    assign stall = accept || (state_q == WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one LATENCY=2 and one LATENCY=0 instance,
// each compared against a word-array reference model of the memory.
module tb_dmem_responder;

    localparam int DEPTH = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_s   [2];
    logic        we_s    [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [31:0] rdata_s [2];
    logic        ready_s [2];
    logic        err_s   [2];
    logic        stall_s [2];

    int          lat [2] = '{2, 0};
    logic [31:0] mem_m [2][DEPTH];
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_lat2 (
        .clock (clock), .reset (reset),
        .req (req_s[0]), .we (we_s[0]), .addr (addr_s[0]), .wdata (wdata_s[0]),
        .rdata (rdata_s[0]), .ready (ready_s[0]), .err (err_s[0]), .stall (stall_s[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_lat0 (
        .clock (clock), .reset (reset),
        .req (req_s[1]), .we (we_s[1]), .addr (addr_s[1]), .wdata (wdata_s[1]),
        .rdata (rdata_s[1]), .ready (ready_s[1]), .err (err_s[1]), .stall (stall_s[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit is_fault(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'(4 * DEPTH));
    endfunction

    // One complete access on unit u; called at a falling edge with the unit idle.
    task automatic access(input int u, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input bit scramble);
        logic [31:0] exp_rd;
        bit          f;
        f      = is_fault(a);
        exp_rd = 32'd0;
        if (!w && !f) exp_rd = mem_m[u][a / 4];
        req_s[u] = 1'b1; we_s[u] = w; addr_s[u] = a; wdata_s[u] = d;
        #1 check("stall_on_req", 32'(stall_s[u]), 32'd1);
        @(posedge clock); #1;
        for (int i = 0; i < lat[u]; i++) begin
            check("wait_stall", 32'(stall_s[u]), 32'd1);
            check("wait_ready", 32'(ready_s[u]), 32'd0);
            check("wait_err",   32'(err_s[u]),   32'd0);
            if (scramble) begin
                addr_s[u]  = $urandom;
                wdata_s[u] = $urandom;
            end
            @(posedge clock); #1;
        end
        check("resp_ready", 32'(ready_s[u]), 32'd1);
        check("resp_stall", 32'(stall_s[u]), 32'd0);
        check("resp_err",   32'(err_s[u]),   32'(f));
        check("resp_rdata", rdata_s[u], exp_rd);
        $display("unit%0d %s addr=0x%08h wdata=0x%08h rdata=0x%08h err=%0b",
                 u, w ? "store" : "load ", a, d, rdata_s[u], err_s[u]);
        req_s[u] = 1'b0;
        if (w && !f) mem_m[u][a / 4] = d;
        @(posedge clock); #1;
        check("idle_ready", 32'(ready_s[u]), 32'd0);
        @(negedge clock);
    endtask

    initial begin
        logic [31:0] a;
        int          u;
        int          r;
        bit          w;

        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_s[k] = 1'b0; we_s[k] = 1'b0; addr_s[k] = 32'd0; wdata_s[k] = 32'd0;
        end
        repeat (2) @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("reset_ready", 32'(ready_s[k]), 32'd0);
            check("reset_err",   32'(err_s[k]),   32'd0);
            check("reset_stall", 32'(stall_s[k]), 32'd0);
            check("reset_rdata", rdata_s[k],      32'd0);
        end
        @(negedge clock);
        reset = 1'b0;

        // Give every word a known value so later loads have a defined reference.
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DEPTH; i++)
                access(k, 1'b1, 32'(i * 4), $urandom, 1'b0);

        access(0, 1'b1, 32'h08, 32'hDEADBEEF, 1'b0);
        access(0, 1'b0, 32'h08, 32'd0, 1'b0);
        access(1, 1'b0, 32'h04, 32'd0, 1'b0);
        access(0, 1'b1, 32'h0A, $urandom, 1'b0);
        access(0, 1'b0, 32'h08, 32'd0, 1'b0);
        access(0, 1'b0, 32'h100, 32'd0, 1'b0);
        access(1, 1'b0, 32'h100, 32'd0, 1'b0);
        access(0, 1'b1, 32'h0C, 32'h12345678, 1'b1);
        access(0, 1'b0, 32'h0C, 32'd0, 1'b0);
        access(1, 1'b1, 32'h0C, 32'hCAFEF00D, 1'b0);
        access(1, 1'b0, 32'h0C, 32'd0, 1'b0);

        // Reset in the middle of a store's wait phase discards the store.
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h10; wdata_s[0] = ~mem_m[0][4];
        @(posedge clock); #1;
        check("pre_reset_stall", 32'(stall_s[0]), 32'd1);
        reset = 1'b1;
        req_s[0] = 1'b0;
        #1;
        check("midreset_ready", 32'(ready_s[0]), 32'd0);
        check("midreset_stall", 32'(stall_s[0]), 32'd0);
        @(posedge clock); #1;
        check("postreset_ready", 32'(ready_s[0]), 32'd0);
        check("postreset_stall", 32'(stall_s[0]), 32'd0);
        check("postreset_err",   32'(err_s[0]),   32'd0);
        req_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 32'h10;
        @(negedge clock);
        reset = 1'b0;
        access(0, 1'b0, 32'h10, 32'd0, 1'b0);

        for (int n = 0; n < 120; n++) begin
            u = int'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r < 7)       a = 32'($urandom_range(0, DEPTH - 1) * 4);
            else if (r == 7) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            else if (r == 8) a = 32'(4 * DEPTH + $urandom_range(0, 15) * 4);
            else             a = $urandom;
            access(u, w, a, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
